// File: rtl/bascomp_pkg.sv
// Shared definitions for the basic computer AC/ALU slice.
//  - op codes decoded by ac_alu
//  - FSM state encoding for ac_alu
//  - E flip-flop command bundle (load enable, clear, data)
//  - default widths
package bascomp_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_SLICE = 4;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDA = 4'd2;
    localparam logic [3:0] OP_CLA = 4'd3;
    localparam logic [3:0] OP_CLE = 4'd4;
    localparam logic [3:0] OP_CMA = 4'd5;
    localparam logic [3:0] OP_CME = 4'd6;
    localparam logic [3:0] OP_CIR = 4'd7;
    localparam logic [3:0] OP_CIL = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADDS   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef struct packed {
        logic en;    // load E this cycle
        logic clr;   // clear E (data forced low)
        logic data;  // new E value
    } e_cmd_t;

endpackage

// File: rtl/ac_slice_adder.sv
// Combinational SLICE-bit adder with carry in/out; one nibble of the serial ADD.
// Ports:
//  a, b       in   SLICE  addends
//  carry_in   in   1      carry from previous slice
//  sum        out  SLICE  slice sum
//  carry_out  out  1      carry into next slice
module ac_slice_adder #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             carry_in,
    output logic [SLICE-1:0] sum,
    output logic             carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, carry_in};

endmodule

// File: rtl/ac_alu.sv
// Accumulator and ALU of the basic computer. Accepts one op per valid/ready handshake,
// executes single-cycle ops in one step and ADD nibble-serially, then spends one COMMIT
// cycle presenting done and the E flip-flop command.
// Ports:
//  clk, reset           clock, async active-low reset
//  op_valid/op_ready    op handshake; op_ready high only in IDLE
//  op, dr_data          op code and memory operand, sampled at accept
//  e_outdata            current E value from the ff
//  ac_data              accumulator; ac_zero / ac_neg flags derived from it
//  done                 one-cycle completion pulse
//  e_indata/ff_en/e_clr E flip-flop command, valid only while done
module ac_alu
    import bascomp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] dr_data,
    input  logic             e_outdata,
    output logic [WIDTH-1:0] ac_data,
    output logic             ac_zero,
    output logic             ac_neg,
    output logic             done,
    output logic             e_indata,
    output logic             ff_en,
    output logic             e_clr
);

    localparam int unsigned NUM_SLICES = WIDTH / SLICE;
    localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

    if ((WIDTH % SLICE) != 0) begin : gen_bad_slice
        $error("ac_alu: WIDTH must be a multiple of SLICE");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    e_cmd_t           e_cmd_q, e_cmd_d;

    // Slice views of AC/DR so the active nibble is picked by the slice counter.
    logic [NUM_SLICES-1:0][SLICE-1:0] ac_slices, dr_slices, ac_slices_d;
    logic [SLICE-1:0] sum_slice;
    logic             carry_out;

    assign ac_slices = ac_q;
    assign dr_slices = dr_q;

    ac_slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .a         (ac_slices[cnt_q]),
        .b         (dr_slices[cnt_q]),
        .carry_in  (carry_q),
        .sum       (sum_slice),
        .carry_out (carry_out)
    );

    always_comb begin
        state_d     = state_q;
        ac_d        = ac_q;
        dr_d        = dr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        e_cmd_d     = '0;
        ac_slices_d = ac_slices;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    state_d = ST_COMMIT;
                    done_d  = 1'b1;
                    case (op)
                        OP_AND: ac_d = ac_q & dr_data;
                        OP_ADD: begin
                            state_d = ST_ADDS;
                            done_d  = 1'b0;
                            dr_d    = dr_data;
                            carry_d = 1'b0;
                            cnt_d   = '0;
                        end
                        OP_LDA: ac_d = dr_data;
                        OP_CLA: ac_d = '0;
                        OP_CLE: begin
                            e_cmd_d.en  = 1'b1;
                            e_cmd_d.clr = 1'b1;
                        end
                        OP_CMA: ac_d = ~ac_q;
                        OP_CME: begin
                            e_cmd_d.en   = 1'b1;
                            e_cmd_d.data = ~e_outdata;
                        end
                        OP_CIR: begin
                            ac_d         = {e_outdata, ac_q[WIDTH-1:1]};
                            e_cmd_d.en   = 1'b1;
                            e_cmd_d.data = ac_q[0];
                        end
                        OP_CIL: begin
                            ac_d         = {ac_q[WIDTH-2:0], e_outdata};
                            e_cmd_d.en   = 1'b1;
                            e_cmd_d.data = ac_q[WIDTH-1];
                        end
                        OP_INC: ac_d = ac_q + WIDTH'(1);
                        default: ;  // undefined code: NOP, still completes
                    endcase
                end
            end
            ST_ADDS: begin
                ac_slices_d[cnt_q] = sum_slice;
                ac_d    = ac_slices_d;
                carry_d = carry_out;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SLICE) begin
                    state_d      = ST_COMMIT;
                    done_d       = 1'b1;
                    cnt_d        = '0;
                    e_cmd_d.en   = 1'b1;
                    e_cmd_d.data = carry_out;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ac_q    <= '0;
            dr_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            e_cmd_q <= '0;
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            dr_q    <= dr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            e_cmd_q <= e_cmd_d;
        end
    end

    assign op_ready = (state_q == ST_IDLE);
    assign ac_data  = ac_q;
    assign ac_zero  = (ac_q == '0);
    assign ac_neg   = ac_q[WIDTH-1];
    assign done     = done_q;
    assign ff_en    = e_cmd_q.en;
    assign e_clr    = e_cmd_q.clr;
    assign e_indata = e_cmd_q.data & ~e_cmd_q.clr;

endmodule

// File: tb/tb_ac_alu.sv
// Directed and random-op bench for ac_alu with a behavioural E flip-flop in the loop.
module tb_ac_alu;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDA = 4'd2;
    localparam logic [3:0] OP_CLA = 4'd3;
    localparam logic [3:0] OP_CLE = 4'd4;
    localparam logic [3:0] OP_CMA = 4'd5;
    localparam logic [3:0] OP_CME = 4'd6;
    localparam logic [3:0] OP_CIR = 4'd7;
    localparam logic [3:0] OP_CIL = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op;
    logic [15:0] dr_data;
    logic        e_outdata;
    logic [15:0] ac_data;
    logic        ac_zero, ac_neg, done, e_indata, ff_en, e_clr;

    logic        e_ff = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ref_ac;
    logic        ref_e;

    logic [15:0] got_ac;
    logic        got_zero, got_neg, got_done, got_en, got_clr, got_ein;
    int          got_lat;

    always #5 clk = ~clk;

    // E flip-flop fed by the DUT command outputs.
    always @(posedge clk) if (ff_en) e_ff <= e_clr ? 1'b0 : e_indata;
    assign e_outdata = e_ff;

    ac_alu dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .dr_data   (dr_data),
        .e_outdata (e_outdata),
        .ac_data   (ac_data),
        .ac_zero   (ac_zero),
        .ac_neg    (ac_neg),
        .done      (done),
        .e_indata  (e_indata),
        .ff_en     (ff_en),
        .e_clr     (e_clr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model(input logic [3:0] o, input logic [15:0] d,
                         output logic [15:0] nac, output logic ne,
                         output logic en, output logic clr);
        logic [16:0] s;
        nac = ref_ac;
        ne  = ref_e;
        en  = 1'b0;
        clr = 1'b0;
        case (o)
            OP_AND: nac = ref_ac & d;
            OP_ADD: begin
                s   = {1'b0, ref_ac} + {1'b0, d};
                nac = s[15:0];
                ne  = s[16];
                en  = 1'b1;
            end
            OP_LDA: nac = d;
            OP_CLA: nac = 16'h0000;
            OP_CLE: begin ne = 1'b0; en = 1'b1; clr = 1'b1; end
            OP_CMA: nac = ~ref_ac;
            OP_CME: begin ne = ~ref_e; en = 1'b1; end
            OP_CIR: begin nac = {ref_e, ref_ac[15:1]}; ne = ref_ac[0]; en = 1'b1; end
            OP_CIL: begin nac = {ref_ac[14:0], ref_e}; ne = ref_ac[15]; en = 1'b1; end
            OP_INC: nac = ref_ac + 16'd1;
            default: ;
        endcase
    endtask

    // Issue one op, wait for done, check against the model, then check E after commit.
    task automatic run_op(input logic [3:0] o, input logic [15:0] d, input bit hold);
        logic [15:0] exp_ac;
        logic        exp_e, exp_en, exp_clr;
        int          exp_lat, n, low;
        n = 0;
        while (!op_ready && n < 20) begin @(negedge clk); n++; end
        check("ready_before_op", op_ready, 1);
        model(o, d, exp_ac, exp_e, exp_en, exp_clr);
        exp_lat = (o == OP_ADD) ? 5 : 1;
        op_valid = 1'b1;
        op       = o;
        dr_data  = d;
        @(posedge clk);
        #1;
        if (!hold) op_valid = 1'b0;
        got_done = 1'b0;
        got_lat  = 0;
        low      = 0;
        while (!got_done && got_lat < 20) begin
            @(negedge clk);
            got_lat++;
            if (!op_ready) low++;
            got_done = done;
            got_ac   = ac_data;
            got_zero = ac_zero;
            got_neg  = ac_neg;
            got_en   = ff_en;
            got_clr  = e_clr;
            got_ein  = e_indata;
        end
        if (hold) op_valid = 1'b0;
        check("done_seen", got_done, 1);
        check("latency", got_lat, exp_lat);
        check("ready_low_cycles", low, exp_lat);
        check("ac_after_done", got_ac, exp_ac);
        check("zero_flag", got_zero, (exp_ac == 16'h0000));
        check("neg_flag", got_neg, exp_ac[15]);
        check("ff_en", got_en, exp_en);
        check("e_clr", got_clr, exp_clr);
        if (exp_en) check("e_indata", got_ein, exp_e);
        @(negedge clk);
        check("done_pulse_width", done, 0);
        check("e_after_commit", e_ff, exp_e);
        ref_ac = exp_ac;
        ref_e  = exp_e;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset    = 1'b0;
        op_valid = 1'b0;
        op       = 4'd0;
        dr_data  = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_ac", ac_data, 16'h0000);
        check("rst_done", done, 0);
        check("rst_ff_en", ff_en, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", op_ready, 1);
        check("rst_zero", ac_zero, 1);
        check("rst_e_clr", e_clr, 0);
        check("rst_e_indata", e_indata, 0);
        ref_ac = 16'h0000;
        ref_e  = 1'b0;

        run_op(OP_LDA, 16'h00FF, 0);
        check("lda_ac", got_ac, 16'h00FF);
        check("lda_zero", got_zero, 0);
        check("lda_ff_en", got_en, 0);

        run_op(OP_LDA, 16'hFFFF, 0);
        run_op(OP_ADD, 16'h0001, 0);
        check("add_wrap_ac", got_ac, 16'h0000);
        check("add_wrap_zero", got_zero, 1);
        check("add_wrap_lat", got_lat, 5);
        check("add_wrap_en", got_en, 1);
        check("add_wrap_carry", got_ein, 1);

        run_op(OP_LDA, 16'h1234, 0);
        run_op(OP_ADD, 16'h0F0F, 0);
        check("add_ac", got_ac, 16'h2143);
        check("add_carry", got_ein, 0);

        run_op(OP_LDA, 16'h0001, 0);
        run_op(OP_CLE, 16'h0000, 0);
        run_op(OP_CIR, 16'h0000, 0);
        check("cir_ac", got_ac, 16'h0000);
        check("cir_e", got_ein, 1);
        check("cir_en", got_en, 1);

        run_op(OP_LDA, 16'h8000, 0);
        run_op(OP_CIL, 16'h0000, 0);
        check("cil_ac", got_ac, 16'h0001);
        check("cil_e", got_ein, 1);

        run_op(OP_CLE, 16'h0000, 0);
        check("cle_en", got_en, 1);
        check("cle_clr", got_clr, 1);
        check("cle_data", got_ein, 0);
        run_op(OP_CME, 16'h0000, 0);
        check("cme_en", got_en, 1);
        check("cme_data", got_ein, 1);

        run_op(OP_LDA, 16'h00FF, 0);
        run_op(OP_CMA, 16'h0000, 0);
        check("cma_ac", got_ac, 16'hFF00);
        check("cma_neg", got_neg, 1);

        run_op(OP_AND, 16'h0F0F, 0);
        check("and_ac", got_ac, 16'h0F00);
        run_op(OP_INC, 16'h0000, 0);
        check("inc_ac", got_ac, 16'h0F01);
        run_op(4'hC, 16'hFFFF, 0);
        check("nop_ac", got_ac, 16'h0F01);
        check("nop_en", got_en, 0);

        // Reset during the second ADDS cycle abandons the add.
        run_op(OP_LDA, 16'h1234, 0);
        op_valid = 1'b1;
        op       = OP_ADD;
        dr_data  = 16'h1111;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ac", ac_data, 16'h0000);
        check("midrst_done", done, 0);
        check("midrst_ff_en", ff_en, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", op_ready, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || ff_en) cnt++;
            @(negedge clk);
        end
        check("midrst_no_done", cnt, 0);
        ref_ac = 16'h0000;

        // op_valid held through an ADD: exactly one completion.
        run_op(OP_LDA, 16'h7FFF, 0);
        run_op(OP_ADD, 16'h0001, 1);
        check("hold_ac", got_ac, 16'h8000);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) cnt++;
            @(negedge clk);
        end
        check("hold_extra_done", cnt, 0);

        for (int i = 0; i < 24; i++) begin
            run_op(4'($urandom_range(0, 11)), 16'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
